jstep_monitor: RTL and testbench

- Receive-side checker and decoder for the CPU stepper bus (one-hot steps 0..5) and the set-phase clock strobe.
- Converts the one-hot step bus into a binary step index. Emits step-start and instruction-done pulses, and counts completed instructions.
- Flags protocol violations: non-one-hot bus, out-of-order step, wrong set-strobe count per step, and stalled step.
- Sits beside the control unit. Debug and bring-up aid. Read-only with respect to the stepper.

---
 rtl/jstep_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_jstep_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jstep_monitor.sv
// Receive-side monitor for the one-hot CPU stepper bus and set-phase strobe.
// Decodes the step index, pulses on step entry and instruction wrap, counts instructions, flags violations.
module jstep_monitor #(
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 64,
  parameter int EXP_SETS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       bos,
  input  logic             clks,
  output logic [2:0]       step,
  output logic             step_start,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       err,
  output logic             err_any
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
  localparam logic [1:0] EXP_SETS_C = 2'(EXP_SETS);

  logic [5:0]       bos_q_r;
  logic             clks_q_r;
  logic             clks_p_r;
  state_t           state_r;
  state_t           state_n;
  logic [2:0]       prev_r;
  logic [2:0]       prev_n;
  logic [7:0]       hold_r;
  logic [7:0]       hold_n;
  logic [1:0]       sets_r;
  logic [1:0]       sets_n;
  logic [2:0]       step_r;
  logic             step_start_r;
  logic             instr_done_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       err_r;
  logic             err_any_r;

  logic [2:0]       ones_s;
  logic [2:0]       pos_s;
  logic [2:0]       idx_s;
  logic             multi_s;
  logic             rise_s;
  logic             start_n;
  logic             done_n;
  logic [3:0]       err_n;

  function automatic logic [2:0] next_step(input logic [2:0] cur);
    if (cur == 3'd5) begin
      next_step = 3'd0;
    end else begin
      next_step = cur + 3'd1;
    end
  endfunction

  // Decode the sampled bus into a step index; anything but exactly one bit is 7.
  always_comb begin
    ones_s = 3'd0;
    pos_s  = 3'd7;
    for (int i = 0; i < 6; i++) begin
      ones_s = ones_s + {2'b00, bos_q_r[i]};
      if (bos_q_r[i]) begin
        pos_s = 3'(i);
      end else begin
        pos_s = pos_s;
      end
    end
    if (ones_s == 3'd1) begin
      idx_s = pos_s;
    end else begin
      idx_s = 3'd7;
    end
    multi_s = (ones_s > 3'd1);
    rise_s  = clks_q_r & ~clks_p_r;
  end

  // Step tracker: next state, hold/set counters, pulses and error flags.
  always_comb begin
    state_n = state_r;
    prev_n  = prev_r;
    hold_n  = hold_r;
    sets_n  = sets_r;
    start_n = 1'b0;
    done_n  = 1'b0;
    err_n   = err_r | {3'b000, multi_s};
    case (state_r)
      IDLE: begin
        if (idx_s != 3'd7) begin
          state_n = RUN;
          start_n = 1'b1;
          prev_n  = idx_s;
          hold_n  = 8'd0;
          sets_n  = {1'b0, rise_s};
        end else begin
          hold_n = 8'd0;
          sets_n = 2'd0;
        end
      end
      RUN: begin
        if (idx_s == 3'd7) begin
          state_n = IDLE;
          hold_n  = 8'd0;
          sets_n  = 2'd0;
        end else if (idx_s == prev_r) begin
          if (hold_r != 8'd255) begin
            hold_n = hold_r + 8'd1;
          end else begin
            hold_n = hold_r;
          end
          // Saturation stops further matches, so the stall flag fires once.
          if ((hold_r != 8'd255) && (hold_r + 8'd1 == MAX_HOLD_C)) begin
            err_n[3] = 1'b1;
          end else begin
            err_n[3] = err_n[3];
          end
          if (rise_s && (sets_r != 2'd3)) begin
            sets_n = sets_r + 2'd1;
          end else begin
            sets_n = sets_r;
          end
        end else begin
          start_n = 1'b1;
          if (idx_s != next_step(prev_r)) begin
            err_n[1] = 1'b1;
          end else begin
            err_n[1] = err_n[1];
          end
          if (sets_r != EXP_SETS_C) begin
            err_n[2] = 1'b1;
          end else begin
            err_n[2] = err_n[2];
          end
          if ((prev_r == 3'd5) && (idx_s == 3'd0)) begin
            done_n = 1'b1;
          end else begin
            done_n = 1'b0;
          end
          prev_n = idx_s;
          hold_n = 8'd0;
          sets_n = {1'b0, rise_s};
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = 8'd0;
        sets_n  = 2'd0;
      end
    endcase
  end

  // Input samples, tracker state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bos_q_r      <= 6'd0;
      clks_q_r     <= 1'b0;
      clks_p_r     <= 1'b0;
      state_r      <= IDLE;
      prev_r       <= 3'd7;
      hold_r       <= 8'd0;
      sets_r       <= 2'd0;
      step_r       <= 3'd7;
      step_start_r <= 1'b0;
      instr_done_r <= 1'b0;
      cnt_r        <= '0;
      err_r        <= 4'd0;
      err_any_r    <= 1'b0;
    end else begin
      bos_q_r      <= bos;
      clks_q_r     <= clks;
      clks_p_r     <= clks_q_r;
      state_r      <= state_n;
      prev_r       <= prev_n;
      hold_r       <= hold_n;
      sets_r       <= sets_n;
      step_r       <= idx_s;
      step_start_r <= start_n;
      instr_done_r <= done_n;
      if (done_n) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      err_r        <= err_n;
      err_any_r    <= |err_n;
    end
  end

  assign step       = step_r;
  assign step_start = step_start_r;
  assign instr_done = instr_done_r;
  assign instr_cnt  = cnt_r;
  assign err        = err_r;
  assign err_any    = err_any_r;

endmodule

// File: tb/tb_jstep_monitor.sv
// Bench for jstep_monitor: directed scenarios plus randomized stepping, checked
// every cycle against a step-level reference model.
module tb_jstep_monitor;

  localparam int CNT_W    = 2;
  localparam int MAX_HOLD = 8;
  localparam int EXP_SETS = 1;

  logic             clk;
  logic             reset;
  logic [5:0]       bos;
  logic             clks;
  logic [2:0]       step;
  logic             step_start;
  logic             instr_done;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       err;
  logic             err_any;

  int checks = 0;
  int errors = 0;
  int seen_starts = 0;
  int seen_dones = 0;

  // Reference model: samples of the inputs, current step tracking, expected outputs.
  logic [5:0]       m_bq;
  logic             m_cq;
  logic             m_cp;
  bit               attached;
  int               cur;
  int               run_len;
  int               pulses;
  logic [2:0]       e_step;
  logic             e_start;
  logic             e_done;
  logic [CNT_W-1:0] e_cnt;
  logic [3:0]       e_err;

  jstep_monitor #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD), .EXP_SETS(EXP_SETS)) dut (
    .clk(clk), .reset(reset), .bos(bos), .clks(clks), .step(step),
    .step_start(step_start), .instr_done(instr_done), .instr_cnt(instr_cnt),
    .err(err), .err_any(err_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [5:0] b, input logic c);
    int  ones;
    int  idx;
    bit  rise;
    int  capped;
    if (r) begin
      m_bq = 6'd0; m_cq = 1'b0; m_cp = 1'b0;
      attached = 0; cur = 7; run_len = 0; pulses = 0;
      e_step = 3'd7; e_start = 1'b0; e_done = 1'b0; e_cnt = '0; e_err = 4'd0;
    end else begin
      ones = $countones(m_bq);
      rise = m_cq && !m_cp;
      idx = 7;
      if (ones == 1) begin
        for (int i = 0; i < 6; i++) if (m_bq[i]) idx = i;
      end
      if (ones > 1) e_err[0] = 1'b1;
      e_start = 1'b0;
      e_done = 1'b0;
      if (idx == 7) begin
        attached = 0;
      end else if (!attached) begin
        attached = 1; cur = idx; run_len = 1; pulses = rise ? 1 : 0; e_start = 1'b1;
      end else if (idx == cur) begin
        run_len++;
        if (run_len == MAX_HOLD + 1) e_err[3] = 1'b1;
        if (rise) pulses++;
      end else begin
        e_start = 1'b1;
        if (idx != (cur + 1) % 6) e_err[1] = 1'b1;
        capped = (pulses > 3) ? 3 : pulses;
        if (capped != EXP_SETS) e_err[2] = 1'b1;
        if (cur == 5 && idx == 0) begin
          e_done = 1'b1;
          e_cnt = e_cnt + 1'b1;
        end
        cur = idx; run_len = 1; pulses = rise ? 1 : 0;
      end
      e_step = 3'(idx);
      m_cp = m_cq; m_cq = c; m_bq = b;
    end
  endtask

  task automatic cycle(input logic [5:0] b, input logic c, input logic r);
    @(negedge clk);
    bos = b; clks = c; reset = r;
    model_step(r, b, c);
    @(posedge clk);
    #1;
    seen_starts += int'(step_start);
    seen_dones  += int'(instr_done);
    chk("step", 16'(step), 16'(e_step));
    chk("step_start", 16'(step_start), 16'(e_start));
    chk("instr_done", 16'(instr_done), 16'(e_done));
    chk("instr_cnt", 16'(instr_cnt), 16'(e_cnt));
    chk("err", 16'(err), 16'(e_err));
    chk("err_any", 16'(err_any), 16'(|e_err));
  endtask

  task automatic hold_step(input logic [5:0] b, input int n, input int p);
    for (int k = 0; k < n; k++) cycle(b, (k % 2 == 1) && (k / 2 < p), 1'b0);
  endtask

  initial begin
    logic [5:0] seq [6];
    int         s;
    int         a;
    int         n;
    int         p;
    logic [5:0] v;
    seq[0] = 6'd1; seq[1] = 6'd2; seq[2] = 6'd4; seq[3] = 6'd8; seq[4] = 6'd16; seq[5] = 6'd32;
    reset = 1'b1; bos = 6'd0; clks = 1'b0;

    // Full instruction 1..6,1 with one strobe per step.
    cycle(6'd0, 1'b0, 1'b1);
    cycle(6'd0, 1'b0, 1'b0);
    seen_starts = 0; seen_dones = 0;
    for (int i = 0; i < 6; i++) hold_step(seq[i], 4, 1);
    hold_step(6'd1, 4, 1);
    cycle(6'd1, 1'b0, 1'b0);
    chk("t1_starts", 16'(seen_starts), 16'd7);
    chk("t1_dones", 16'(seen_dones), 16'd1);
    chk("t1_cnt", 16'(instr_cnt), 16'd1);
    chk("t1_err", 16'(err), 16'd0);

    // Five more instructions: counter 1 -> 2,3,0,1,2.
    for (int j = 0; j < 5; j++) begin
      for (int i = 1; i < 6; i++) hold_step(seq[i], 3, 1);
      hold_step(seq[0], 3, 1);
    end
    chk("t2_cnt", 16'(instr_cnt), 16'd2);
    chk("t2_err", 16'(err), 16'd0);

    // Skipped step 2 -> 4.
    cycle(6'd0, 1'b0, 1'b1);
    hold_step(6'd2, 4, 1);
    cycle(6'd8, 1'b0, 1'b0);
    cycle(6'd8, 1'b0, 1'b0);
    chk("t3_err", 16'(err), 16'b0010);
    chk("t3_step", 16'(step), 16'd3);
    chk("t3_start", 16'(step_start), 16'd1);

    // Multi-hot glitch, then re-entry without an order error.
    cycle(6'd0, 1'b0, 1'b1);
    hold_step(6'd1, 3, 1);
    cycle(6'b000011, 1'b0, 1'b0);
    cycle(6'd4, 1'b0, 1'b0);
    chk("t4_step", 16'(step), 16'd7);
    hold_step(6'd4, 4, 1);
    chk("t4_err", 16'(err), 16'b0001);

    // Stall past MAX_HOLD, then a step without any strobe.
    cycle(6'd0, 1'b0, 1'b1);
    hold_step(6'd4, MAX_HOLD + 5, 1);
    chk("t5_stall", 16'(err), 16'b1000);
    hold_step(6'd8, 3, 0);
    hold_step(6'd16, 3, 1);
    chk("t5_err", 16'(err), 16'b1100);

    // Reset mid-step clears everything; resume without an order error.
    cycle(6'd16, 1'b0, 1'b1);
    chk("t6_rst_err", 16'(err), 16'd0);
    chk("t6_rst_step", 16'(step), 16'd7);
    hold_step(6'd32, 4, 1);
    hold_step(6'd1, 4, 1);
    chk("t6_err", 16'(err), 16'd0);
    chk("t6_cnt", 16'(instr_cnt), 16'd1);

    // Randomized stepping with occasional skips, glitches, gaps and resets.
    cycle(6'd0, 1'b0, 1'b1);
    s = 0;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 15) == 0) cycle(6'd0, 1'b0, 1'b1);
      a = int'($urandom_range(0, 19));
      if (a < 14) begin
        s = (s + 1) % 6; v = seq[s];
      end else if (a < 16) begin
        s = int'($urandom_range(0, 5)); v = seq[s];
      end else if (a < 18) begin
        v = 6'd0;
      end else begin
        v = seq[$urandom_range(0, 5)] | seq[$urandom_range(0, 5)];
      end
      p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : 1;
      n = int'($urandom_range(1, 12));
      if (n < 2 * p) n = 2 * p;
      hold_step(v, n, p);
    end
    cycle(6'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
